ram_access_ctrl: RTL
====================

// Module: ram_access_ctrl
// PURPOSE
//   Request/response front end sitting directly upstream of the 16x8 single-port RAM.
//   Accepts valid/ready write and read-burst requests and sequences them onto the RAM's addr/wr/din pins.
//   RAM timing: one cycle of read latency, dout registered on the posedge where wr=0.
//   Captures read data into a held, valid/ready response stream with a last-beat flag.
// PARAMETERS
//   ADDR_W  4  RAM address width; 2**ADDR_W words
//   DATA_W  8  RAM data width
//   LEN_W   4  burst length field width; beats = req_len+1 (1..16)
// PORTS
//   clk        in   1       single clock, all logic posedge
//   rst_n      in   1       asynchronous active-low reset
//   req_valid  in   1       request present
//   req_ready  out  1       request accepted when req_valid&&req_ready at posedge
//   req_wr     in   1       1=write single word, 0=read burst
//   req_addr   in   ADDR_W  start address
//   req_wdata  in   DATA_W  write data (ignored for reads)
//   req_len    in   LEN_W   read beats minus one (ignored for writes)
//   rsp_valid  out  1       read data beat available
//   rsp_ready  in   1       consumer accepts beat
//   rsp_rdata  out  DATA_W  read data, stable while rsp_valid
//   rsp_last   out  1       final beat of burst, qualified by rsp_valid
//   busy       out  1       state != IDLE
//   ram_addr   out  ADDR_W  to RAM addr (registered)
//   ram_wr     out  1       to RAM wr (registered)
//   ram_din    out  DATA_W  to RAM din (registered)
//   ram_dout   in   DATA_W  from RAM dout
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE; ram_wr=0, ram_addr=0, ram_din=0.
//     Also rsp_valid=0, rsp_last=0, rsp_rdata=0, beat counter=0.
//     Reset never produces a RAM write.
//   req_ready = (state==IDLE); no request queueing; one transaction in flight.
//   FSM states: IDLE, WR, RD_ADDR, RD_CAP, RSP.
//   IDLE: write accept at edge E -> WR.
//     Loads ram_addr<=req_addr, ram_din<=req_wdata, ram_wr<=1.
//   IDLE: read accept at edge E -> RD_ADDR.
//     Loads ram_addr<=req_addr, ram_wr<=0, beats_left<=req_len.
//   WR: exactly one cycle; the RAM writes at edge E+1.
//     At E+1: ram_wr<=0, state->IDLE; next request can be accepted at E+2.
//   RD_ADDR: one cycle; the RAM samples mem[ram_addr] at its closing edge -> RD_CAP.
//   RD_CAP: one cycle; rsp_rdata<=ram_dout, rsp_last<=(beats_left==0), rsp_valid<=1 -> RSP.
//     First beat: rsp_valid high from edge E+2, i.e. 2 cycles after the accept edge.
//   RSP: hold rsp_valid, rsp_rdata and rsp_last stable until rsp_valid&&rsp_ready at edge H.
//     At H, if beats_left==0: rsp_valid<=0, rsp_last<=0, state->IDLE.
//     At H, else: rsp_valid<=0, ram_addr<=ram_addr+1 mod 2**ADDR_W, beats_left-=1, state->RD_ADDR.
//     The next beat is valid at H+2; peak throughput is 1 beat per 3 cycles.
//   Address wrap: 15+1 -> 0; bursts wrap silently; no error flag.
//   ram_wr is high only in WR, for exactly one cycle per accepted write.
//   Write then read to the same address: the read returns the new data (write commits before the read samples).
//   Requests with req_valid low, or while busy, have no effect; req_* inputs are sampled only at accept.
//   Reset mid-burst: in-flight beats are dropped, no further rsp_valid, ram_wr forced 0 immediately.
//     RAM contents are not cleared.
//   rsp_ready while rsp_valid=0 is ignored.
// TESTING
//   Write addr 3 data 0xA5.
//     -> ram_wr=1 for one cycle with ram_addr=3, ram_din=0xA5; req_ready low 1 cycle.
//   Then read addr 3 len 0 with rsp_ready=1.
//     -> rsp_valid at accept+2, rsp_rdata=0xA5, rsp_last=1.
//   Preload 14..1 with 0x0E,0x0F,0x00,0x01; read addr 14 len 3.
//     -> 4 beats 0x0E,0x0F,0x00,0x01, spaced 3 cycles apart; rsp_last only on the 4th.
//   Read len 1 with rsp_ready low 5 cycles on beat 0.
//     -> rsp_valid/rsp_rdata/rsp_last held unchanged; ram_addr unchanged.
//     Beat 1 arrives 2 cycles after the ready handshake.
//   Assert rst_n low in RD_CAP of a 4-beat burst.
//     -> outputs take reset values asynchronously; no rsp_valid after release.
//     req_ready=1 the first cycle after release.
//   Back-to-back: write addr 7 = 0x3C, then a read of addr 7 presented continuously.
//     -> read accepted at write-accept+2, returns 0x3C.
//     ram_wr never asserted during reset or any read.

Source files
------------

// File: rtl/ram_access_ctrl_if.sv
// Request/response bundle between a requester and the RAM access controller.
interface ram_access_ctrl_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 4
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [LEN_W-1:0]  req_len;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_last;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_last
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_last
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// Front end for a single-port 1-cycle-latency RAM: single-word writes and
// read bursts, with read beats returned on a held valid/ready stream.
module ram_access_ctrl #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_access_ctrl_if.slave  bus,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR      = 3'd1;
  localparam logic [2:0] RD_ADDR = 3'd2;
  localparam logic [2:0] RD_CAP  = 3'd3;
  localparam logic [2:0] RSP     = 3'd4;

  logic [2:0]        state_q,     state_d;
  logic [LEN_W-1:0]  beats_q,     beats_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic              ram_wr_d;
  logic [DATA_W-1:0] ram_din_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_last_q,  rsp_last_d;
  logic              req_ready_q;

  // Next-state and datapath updates; every register holds unless changed below.
  always_comb begin
    state_d     = state_q;
    beats_d     = beats_q;
    ram_addr_d  = ram_addr;
    ram_wr_d    = ram_wr;
    ram_din_d   = ram_din;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_last_d  = rsp_last_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          ram_addr_d = bus.req_addr;
          if (bus.req_wr) begin
            ram_din_d = bus.req_wdata;
            ram_wr_d  = 1'b1;
            state_d   = WR;
          end else begin
            ram_wr_d  = 1'b0;
            beats_d   = bus.req_len;
            state_d   = RD_ADDR;
          end
        end
      end
      WR: begin
        ram_wr_d = 1'b0;
        state_d  = IDLE;
      end
      RD_ADDR: state_d = RD_CAP;
      RD_CAP: begin
        rsp_rdata_d = ram_dout;
        rsp_last_d  = (beats_q == LEN_W'(0));
        rsp_valid_d = 1'b1;
        state_d     = RSP;
      end
      RSP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (beats_q == LEN_W'(0)) begin
            rsp_last_d = 1'b0;
            state_d    = IDLE;
          end else begin
            // Burst addresses wrap silently at the top of the RAM.
            ram_addr_d = ram_addr + ADDR_W'(1);
            beats_d    = beats_q - LEN_W'(1);
            state_d    = RD_ADDR;
          end
        end
      end
      default: begin
        ram_wr_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // req_ready and busy are registered decodes of the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beats_q     <= '0;
      ram_addr    <= '0;
      ram_wr      <= 1'b0;
      ram_din     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_last_q  <= 1'b0;
      req_ready_q <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      beats_q     <= beats_d;
      ram_addr    <= ram_addr_d;
      ram_wr      <= ram_wr_d;
      ram_din     <= ram_din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_last_q  <= rsp_last_d;
      req_ready_q <= (state_d == IDLE);
      busy        <= (state_d != IDLE);
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_last  = rsp_last_q;

endmodule
